// File: rtl/debug_run_ctrl.sv
// rtl/debug_run_ctrl.sv - run/halt/single-step sequencer with breakpoints, debounced buttons and view address
module debug_run_ctrl #(
    parameter int          ADDR_W       = 8,
    parameter int          NUM_BP       = 2,
    parameter int          DEBOUNCE_CYC = 16,
    parameter logic [3:0]  FETCH_STATE  = 4'd0,
    localparam int         BP_SEL_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cont,
    input  logic                step,
    input  logic                inc,
    input  logic                dec,
    input  logic                bp_set,
    input  logic                bp_clr,
    input  logic [BP_SEL_W-1:0] bp_sel,
    input  logic [31:0]         pc,
    input  logic [3:0]          state_in,
    output logic                cpu_en,
    output logic [ADDR_W-1:0]   view_addr,
    output logic                halted,
    output logic                bp_hit,
    output logic [15:0]         led
);

    localparam int NIN   = 6;
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    // Input order: 0 cont, 1 step, 2 inc, 3 dec, 4 bp_set, 5 bp_clr
    logic [NIN-1:0] raw, sync1, sync2, lvl;
    logic [NIN-1:1] lvl_q, pulse;
    logic [CNT_W-1:0] cnt [NIN];

    logic cont_lvl, step_p, inc_p, dec_p, set_p, clr_p;

    typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_DRAIN} state_t;
    state_t state, state_next;

    logic at_fetch, bp_match, bp_break, skip, en_seen;
    logic [ADDR_W-1:0] bp_addr [NUM_BP];
    logic [NUM_BP-1:0] bp_valid;
    logic unused_pc;

    assign raw       = {bp_clr, bp_set, dec, inc, step, cont};
    assign pulse     = lvl[NIN-1:1] & ~lvl_q;
    assign cont_lvl  = lvl[0];
    assign step_p    = pulse[1];
    assign inc_p     = pulse[2];
    assign dec_p     = pulse[3];
    assign set_p     = pulse[4];
    assign clr_p     = pulse[5];
    assign at_fetch  = (state_in == FETCH_STATE);
    assign halted    = (state == S_HALT);
    assign unused_pc = ^{pc[31:10], pc[1:0]};

    // Two-flop synchroniser for the asynchronous board inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: a level only follows its input after DEBOUNCE_CYC consecutive differing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            lvl_q <= lvl[NIN-1:1];
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    lvl[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Any valid breakpoint matching the current instruction word address
    always_comb begin
        bp_match = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_valid[i] && (bp_addr[i] == pc[ADDR_W+1:2])) bp_match = 1'b1;
        end
    end

    // A breakpoint is only honoured on a fetch, and never on the fetch we resumed from
    assign bp_break = (state == S_RUN) && cont_lvl && at_fetch && !skip && bp_match;

    // Next-state logic; DRAIN with the enable already low means it was entered on the boundary
    always_comb begin
        state_next = state;
        case (state)
            S_HALT: begin
                if (step_p)                    state_next = S_STEP;
                else if (cont_lvl && !bp_hit)  state_next = S_RUN;
            end
            S_RUN: begin
                if (!cont_lvl || bp_break)     state_next = S_DRAIN;
            end
            S_STEP: begin
                if (en_seen && at_fetch)       state_next = S_HALT;
            end
            S_DRAIN: begin
                if (at_fetch || !cpu_en)       state_next = S_HALT;
            end
            default:                           state_next = S_HALT;
        endcase
    end

    // State register, registered CPU enable and run bookkeeping flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_HALT;
            cpu_en  <= 1'b0;
            bp_hit  <= 1'b0;
            skip    <= 1'b0;
            en_seen <= 1'b0;
        end else begin
            state  <= state_next;
            // Enable stops right after the fetch cycle that ends a run or step
            cpu_en <= (state_next == S_RUN) || (state_next == S_STEP) ||
                      ((state_next == S_DRAIN) && !at_fetch);

            if ((state == S_HALT) && (state_next == S_RUN))
                skip <= 1'b1;
            else if ((state == S_RUN) && !at_fetch)
                skip <= 1'b0;

            if ((state != S_STEP) && (state_next == S_STEP))
                en_seen <= 1'b0;
            else if ((state == S_STEP) && cpu_en)
                en_seen <= 1'b1;

            if ((state == S_HALT) && step_p)
                bp_hit <= 1'b0;
            else if (!cont_lvl)
                bp_hit <= 1'b0;
            else if (bp_break)
                bp_hit <= 1'b1;
        end
    end

    // View address moves on inc/dec pulses and wraps; simultaneous pulses cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            view_addr <= '0;
        end else if (inc_p && !dec_p) begin
            view_addr <= view_addr + 1'b1;
        end else if (dec_p && !inc_p) begin
            view_addr <= view_addr - 1'b1;
        end
    end

    // Breakpoint table; clear beats a simultaneous set, out-of-range slots are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_valid <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
        end else if (clr_p) begin
            bp_valid <= '0;
        end else if (set_p && (int'(bp_sel) < NUM_BP)) begin
            bp_addr[bp_sel]  <= view_addr;
            bp_valid[bp_sel] <= 1'b1;
        end
    end

    // Registered status LEDs
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= {state == S_RUN, state == S_HALT, bp_hit, state == S_STEP, state_in, pc[9:2]};
        end
    end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// tb/tb_debug_run_ctrl.sv - scoreboard bench for debug_run_ctrl with a 4-state CPU model
module tb_debug_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cont = 1'b0, step = 1'b0, inc = 1'b0, dec = 1'b0;
    logic        bp_set = 1'b0, bp_clr = 1'b0;
    logic [0:0]  bp_sel = 1'b0;
    logic [31:0] pc;
    logic [3:0]  cstate;
    logic        cpu_en, halted, bp_hit;
    logic [7:0]  view_addr;
    logic [15:0] led;

    int vectors = 0;
    int miscompares = 0;
    bit mon_on = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic        bp;
        int          en;
        bit          chk_pc;
    } halt_rec_t;

    halt_rec_t  halt_q[$];
    logic [7:0] view_q[$];

    debug_run_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cont      (cont),
        .step      (step),
        .inc       (inc),
        .dec       (dec),
        .bp_set    (bp_set),
        .bp_clr    (bp_clr),
        .bp_sel    (bp_sel),
        .pc        (pc),
        .state_in  (cstate),
        .cpu_en    (cpu_en),
        .view_addr (view_addr),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .led       (led)
    );

    always #5 clk = ~clk;

    // CPU model: 4 states per instruction, fetch = 0, 8-instruction loop 0x00..0x1C
    always @(posedge clk) begin
        if (rst) begin
            cstate <= 4'd0;
            pc     <= 32'd0;
        end else if (cpu_en) begin
            if (cstate == 4'd3) begin
                cstate <= 4'd0;
                pc     <= (pc == 32'h1C) ? 32'd0 : pc + 32'd4;
            end else begin
                cstate <= cstate + 4'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event seen but none expected (view=%0h pc=%0h)", name, view_addr, pc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_halt(input logic [31:0] p, input logic b, input int en, input bit cp);
        halt_rec_t r;
        r.pc = p; r.bp = b; r.en = en; r.chk_pc = cp;
        halt_q.push_back(r);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            1: step   = v;
            2: inc    = v;
            3: dec    = v;
            4: bp_set = v;
            5: bp_clr = v;
            default: ;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(22);
        set_btn(b, 1'b0);
        tick(25);
    endtask

    // Monitor: pops expectations whenever the DUT halts or changes its view address
    int       en_cnt = 0;
    logic     prev_halted = 1'b1, prev_en = 1'b0;
    logic [7:0] prev_view = 8'd0;
    always @(negedge clk) begin
        if (mon_on) begin
            if (cpu_en) en_cnt++;
            if (halted && !prev_halted) begin
                if (halt_q.size() == 0) begin
                    fail("unexpected_halt");
                end else begin
                    halt_rec_t r;
                    r = halt_q.pop_front();
                    if (r.chk_pc) chk("halt_pc", pc, r.pc);
                    chk("halt_bp_hit", {31'd0, bp_hit}, {31'd0, r.bp});
                    if (r.en >= 0) chk("halt_en_cycles", en_cnt, r.en);
                end
                en_cnt = 0;
            end
            if (view_addr != prev_view) begin
                if (view_q.size() == 0) fail("unexpected_view");
                else chk("view_addr", {24'd0, view_addr}, {24'd0, view_q.pop_front()});
            end
            if (prev_en && !cpu_en && !rst)
                chk("en_fall_after_fetch", {28'd0, cstate}, 32'd1);
        end
        prev_halted = halted;
        prev_view   = view_addr;
        prev_en     = cpu_en;
    end

    initial begin
        // 1: reset with every button held
        {cont, step, inc, dec, bp_set, bp_clr} = 6'b111111;
        tick(3);
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_view", {24'd0, view_addr}, 32'd0);
        chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        {cont, step, inc, dec, bp_set, bp_clr} = 6'b000000;
        rst = 1'b0;
        mon_on = 1'b1;
        tick(40);
        chk("rel_view", {24'd0, view_addr}, 32'd0);
        chk("rel_halted", {31'd0, halted}, 32'd1);
        chk("rel_cpu_en", {31'd0, cpu_en}, 32'd0);

        // 2: single step from reset fetch, held well past debounce
        exp_halt(32'h4, 1'b0, 5, 1'b1);
        step = 1'b1;
        tick(40);
        step = 1'b0;
        tick(25);

        // 3: breakpoint at view 0x03 -> pc 0x0C, then resume and re-hit after the loop
        rst = 1'b1; tick(1); rst = 1'b0;
        view_q.push_back(8'h01); press(2);
        view_q.push_back(8'h02); press(2);
        view_q.push_back(8'h03); press(2);
        bp_sel = 1'b0;
        press(4);
        exp_halt(32'hC, 1'b1, 13, 1'b1);
        cont = 1'b1;
        tick(70);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_led", {16'd0, led}, 32'h6103);
        cont = 1'b0;
        tick(30);
        chk("bp_hit_cleared", {31'd0, bp_hit}, 32'd0);
        exp_halt(32'hC, 1'b1, 32, 1'b1);
        cont = 1'b1;
        tick(70);

        // Resume skip: breakpoint on the fetch the CPU is parked at
        cont = 1'b0;
        view_q.push_back(8'h00);
        rst = 1'b1; tick(1); rst = 1'b0;
        bp_sel = 1'b1;
        press(4);
        exp_halt(32'h0, 1'b1, 33, 1'b1);
        cont = 1'b1;
        tick(80);

        // 4: view address wrap and cancelling inc+dec (held at breakpoint with cont=1)
        view_q.push_back(8'hFF); press(3);
        view_q.push_back(8'h00); press(2);
        view_q.push_back(8'hFF); press(3);
        inc = 1'b1; dec = 1'b1;
        tick(22);
        inc = 1'b0; dec = 1'b0;
        tick(25);
        chk("inc_dec_cancel", {24'd0, view_addr}, 32'hFF);
        chk("bp_hold_halted", {31'd0, halted}, 32'd1);

        // bp_set with bp_clr: clear wins, so the run is not stopped
        bp_sel = 1'b0;
        bp_set = 1'b1; bp_clr = 1'b1;
        tick(22);
        bp_set = 1'b0; bp_clr = 1'b0;
        tick(25);
        cont = 1'b0;
        tick(30);
        cont = 1'b1;
        tick(80);
        chk("run_after_clr", {31'd0, halted}, 32'd0);

        // 5: drop cont mid-run, must drain to a fetch boundary
        exp_halt(32'h0, 1'b0, -1, 1'b0);
        cont = 1'b0;
        tick(60);
        chk("drain_halted", {31'd0, halted}, 32'd1);

        // 6: reset in the middle of a step, then a short glitch on inc
        view_q.push_back(8'h00); press(2);
        press(4);
        step = 1'b1;
        for (int i = 0; i < 40 && !cpu_en; i++) tick(1);
        chk("step_started", {31'd0, cpu_en}, 32'd1);
        tick(2);
        exp_halt(32'h0, 1'b0, -1, 1'b1);
        rst = 1'b1; step = 1'b0;
        tick(1);
        chk("rst_step_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_step_halted", {31'd0, halted}, 32'd1);
        tick(1);
        rst = 1'b0;
        inc = 1'b1; tick(8); inc = 1'b0;
        tick(30);
        chk("glitch_view", {24'd0, view_addr}, 32'd0);
        cont = 1'b1;
        tick(90);
        chk("bp_cleared_by_rst", {31'd0, halted}, 32'd0);
        exp_halt(32'h0, 1'b0, -1, 1'b0);
        cont = 1'b0;
        tick(40);

        while (halt_q.size() > 0) begin
            void'(halt_q.pop_front());
            vectors++; miscompares++;
            $display("FAIL halt_missing: expected halt never occurred");
        end
        while (view_q.size() > 0) begin
            vectors++; miscompares++;
            $display("FAIL view_missing: got %0h expected %0h", view_addr, view_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
